// File: rtl/branch_ctrl_pkg.sv
// Shared decode constants and FSM encoding for the branch control unit.
// Used by branch_cond_eval and branch_ctrl_unit.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FUNC_JR    = 6'b001000;
  localparam logic [5:0] FUNC_JALR  = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic is_ctrl;
    logic taken;
    logic link;
  } cond_t;

endpackage

// File: rtl/branch_ctrl_unit_if.sv
// Operand/redirect bundle between ALU, branch control unit and fetch.
// BRANCH_STATS_EN adds the branch_cnt/taken_cnt statistics signals.
interface branch_ctrl_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic [31:0]     instruction;
  logic [XLEN-1:0] target;
  logic            cmp_eq;
  logic            cmp_ltz;
  logic            cmp_eqz;
  logic            JF;
  logic [XLEN-1:0] pcsrc;
  logic            link_we;
  logic            flush;
  logic            target_err;
`ifdef BRANCH_STATS_EN
  logic [31:0]     branch_cnt;
  logic [31:0]     taken_cnt;

  modport master (
    output valid_in, instruction, target, cmp_eq, cmp_ltz, cmp_eqz,
    input  JF, pcsrc, link_we, flush, target_err, branch_cnt, taken_cnt
  );
  modport slave (
    input  valid_in, instruction, target, cmp_eq, cmp_ltz, cmp_eqz,
    output JF, pcsrc, link_we, flush, target_err, branch_cnt, taken_cnt
  );
`else
  modport master (
    output valid_in, instruction, target, cmp_eq, cmp_ltz, cmp_eqz,
    input  JF, pcsrc, link_we, flush, target_err
  );
  modport slave (
    input  valid_in, instruction, target, cmp_eq, cmp_ltz, cmp_eqz,
    output JF, pcsrc, link_we, flush, target_err
  );
`endif
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational MIPS jump/branch decode: classifies the op and resolves the
// branch condition from the ALU compare flags.
module branch_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [5:0] func,
  input  logic       cmp_eq,
  input  logic       cmp_ltz,
  input  logic       cmp_eqz,
  output cond_t      cond
);

  always_comb begin
    cond = '0;
    case (op)
      OP_SPECIAL: begin
        if (func == FUNC_JR)        cond = '{is_ctrl: 1'b1, taken: 1'b1, link: 1'b0};
        else if (func == FUNC_JALR) cond = '{is_ctrl: 1'b1, taken: 1'b1, link: 1'b1};
      end
      OP_J:    cond = '{is_ctrl: 1'b1, taken: 1'b1,    link: 1'b0};
      OP_JAL:  cond = '{is_ctrl: 1'b1, taken: 1'b1,    link: 1'b1};
      OP_BEQ:  cond = '{is_ctrl: 1'b1, taken: cmp_eq,  link: 1'b0};
      OP_BNE:  cond = '{is_ctrl: 1'b1, taken: !cmp_eq, link: 1'b0};
      OP_BLEZ: cond = '{is_ctrl: 1'b1, taken: cmp_ltz | cmp_eqz,    link: 1'b0};
      OP_BGTZ: cond = '{is_ctrl: 1'b1, taken: !(cmp_ltz | cmp_eqz), link: 1'b0};
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   cond = '{is_ctrl: 1'b1, taken: cmp_ltz,  link: 1'b0};
          RT_BGEZ:   cond = '{is_ctrl: 1'b1, taken: !cmp_ltz, link: 1'b0};
          RT_BLTZAL: cond = '{is_ctrl: 1'b1, taken: cmp_ltz,  link: 1'b1};
          RT_BGEZAL: cond = '{is_ctrl: 1'b1, taken: !cmp_ltz, link: 1'b1};
          default:   cond = '0;
        endcase
      end
      default: cond = '0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Next-PC control: registered redirect/link/misalign pulses plus a wrong-path
// squash FSM. Define BRANCH_STATS_EN for saturating branch/taken counters.
module branch_ctrl_unit
  import branch_ctrl_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              FLUSH_CYCLES  = 1,
  parameter logic [XLEN-1:0] NOTTAKEN_CODE = {{(XLEN-1){1'b0}}, 1'b1}
) (
  input logic              CLOCK,
  input logic              RESET,
  branch_ctrl_unit_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FC_M1 = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  state_e          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  cond_t           cond_p0;
  logic            accept_p0, aligned_p0, redirect_p0, misalign_p0;
  logic            jf_p1, link_we_p1, target_err_p1;
  logic [XLEN-1:0] pcsrc_p1;
  logic            unused_instr;

  assign unused_instr = ^{bus.instruction[25:21], bus.instruction[15:6]};

  branch_cond_eval u_cond (
    .op      (bus.instruction[31:26]),
    .rt      (bus.instruction[20:16]),
    .func    (bus.instruction[5:0]),
    .cmp_eq  (bus.cmp_eq),
    .cmp_ltz (bus.cmp_ltz),
    .cmp_eqz (bus.cmp_eqz),
    .cond    (cond_p0)
  );

  // p0: operands of the current slot; squashed slots are never accepted
  assign accept_p0   = bus.valid_in && (state == RUN);
  assign aligned_p0  = (bus.target[1:0] == 2'b00);
  assign redirect_p0 = accept_p0 && cond_p0.taken && aligned_p0;
  assign misalign_p0 = accept_p0 && cond_p0.taken && !aligned_p0;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (redirect_p0 && (FLUSH_CYCLES > 0)) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FC_M1);
        end
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // p1: registered redirect outputs, one cycle after sampling
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      jf_p1         <= 1'b0;
      link_we_p1    <= 1'b0;
      target_err_p1 <= 1'b0;
      pcsrc_p1      <= NOTTAKEN_CODE;
    end else begin
      jf_p1         <= redirect_p0;
      link_we_p1    <= accept_p0 && cond_p0.link;
      target_err_p1 <= misalign_p0;
      pcsrc_p1      <= redirect_p0 ? bus.target : NOTTAKEN_CODE;
    end
  end

  assign bus.JF         = jf_p1;
  assign bus.link_we    = link_we_p1;
  assign bus.target_err = target_err_p1;
  assign bus.pcsrc      = pcsrc_p1;
  assign bus.flush      = (state == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_p1, taken_cnt_p1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      branch_cnt_p1 <= '0;
      taken_cnt_p1  <= '0;
    end else begin
      branch_cnt_p1 <= sat_inc(branch_cnt_p1, accept_p0 && cond_p0.is_ctrl);
      taken_cnt_p1  <= sat_inc(taken_cnt_p1, redirect_p0);
    end
  end

  assign bus.branch_cnt = branch_cnt_p1;
  assign bus.taken_cnt  = taken_cnt_p1;
`endif

endmodule
